// File: rtl/share_io_ctrl_pkg.sv
// Shared configuration for the share I/O controller: bus width, share counts,
// command encodings, FSM state type and an index-width helper.
package share_io_ctrl_pkg;

    localparam int CFG_BUSW        = 32;
    localparam int CFG_STATESHARES = 2;
    localparam int CFG_KEYSHARES   = 2;

    typedef enum logic [1:0] {
        OP_LOAD_STATE   = 2'b00,
        OP_LOAD_KEY     = 2'b01,
        OP_RUN          = 2'b10,
        OP_UNLOAD_STATE = 2'b11
    } cmd_op_e;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_LOAD_S,
        ST_LOAD_K,
        ST_RUN,
        ST_UNLOAD
    } ctrl_state_e;

    // Index counters keep at least one bit even when only one value exists.
    function automatic int idx_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/share_io_if.sv
// Command, word-transfer and TBC handshake bundle between the share I/O
// controller (slave) and the surrounding system (master).
interface share_io_if
    import share_io_ctrl_pkg::*;
#(
    parameter int BUSW   = CFG_BUSW,
    parameter int WIDX_W = idx_width(128 / CFG_BUSW),
    parameter int SIDX_W = idx_width(CFG_STATESHARES > CFG_KEYSHARES ? CFG_STATESHARES : CFG_KEYSHARES)
) ();

    logic              cmd_valid;
    logic [1:0]        cmd_op;
    logic              cmd_ready;
    logic              din_valid;
    logic              din_ready;
    logic [BUSW-1:0]   din;
    logic [BUSW-1:0]   wdata;
    logic              dout_valid;
    logic              dout_ready;
    logic              state_we;
    logic              key_we;
    logic [WIDX_W-1:0] word_idx;
    logic [SIDX_W-1:0] share_idx;
    logic              tbc_start;
    logic              tbc_done;
    logic              busy;

    modport slave (
        input  cmd_valid, cmd_op, din_valid, din, dout_ready, tbc_done,
        output cmd_ready, din_ready, wdata, dout_valid, state_we, key_we,
               word_idx, share_idx, tbc_start, busy
    );

    modport master (
        output cmd_valid, cmd_op, din_valid, din, dout_ready, tbc_done,
        input  cmd_ready, din_ready, wdata, dout_valid, state_we, key_we,
               word_idx, share_idx, tbc_start, busy
    );

endinterface

// File: rtl/share_word_counter.sv
// Share-interleaved word counter: share index is the inner digit, word index
// the outer digit; both wrap to zero after the final share of the final word.
module share_word_counter
    import share_io_ctrl_pkg::*;
#(
    parameter int SHARES = 2,
    parameter int WORDS  = 4,
    parameter int WIDX_W = 2,
    parameter int SIDX_W = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              clr,
    input  logic              adv,
    output logic [WIDX_W-1:0] word_idx,
    output logic [SIDX_W-1:0] share_idx,
    output logic              last
);

    localparam logic [SIDX_W-1:0] SLAST = SIDX_W'(SHARES - 1);
    localparam logic [WIDX_W-1:0] WLAST = WIDX_W'(WORDS - 1);

    always_ff @(posedge clk) begin
        if (rst || clr) begin
            word_idx  <= '0;
            share_idx <= '0;
        end else if (adv) begin
            if (share_idx == SLAST) begin
                share_idx <= '0;
                word_idx  <= (word_idx == WLAST) ? '0 : word_idx + 1'b1;
            end else begin
                share_idx <= share_idx + 1'b1;
            end
        end
    end

    assign last = (share_idx == SLAST) && (word_idx == WLAST);

endmodule

// File: rtl/share_io_ctrl.sv
// Sequencer for masked state/key loading, TBC start and state unloading over a
// share-interleaved word bus; reset suppresses every handshake in its cycle.
module share_io_ctrl
    import share_io_ctrl_pkg::*;
#(
    parameter int BUSW        = CFG_BUSW,
    parameter int STATESHARES = CFG_STATESHARES,
    parameter int KEYSHARES   = CFG_KEYSHARES
) (
    input  logic     clk,
    input  logic     rst,
    share_io_if.slave bus
);

    localparam int WORDS  = 128 / BUSW;
    localparam int MAXSH  = (STATESHARES > KEYSHARES) ? STATESHARES : KEYSHARES;
    localparam int WIDX_W = idx_width(WORDS);
    localparam int SIDX_W = idx_width(MAXSH);

    ctrl_state_e       state_q, state_d;
    logic              run_started_q;
    logic              s_adv, k_adv, s_last, k_last, idle_clr;
    logic [WIDX_W-1:0] s_word, k_word;
    logic [SIDX_W-1:0] s_share, k_share;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= ST_IDLE;
            run_started_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            run_started_q <= (state_q == ST_RUN);
        end
    end

    // run_started_q is low only in the first RUN cycle, which makes tbc_start a single pulse.
    always_comb begin
        state_d       = state_q;
        bus.cmd_ready = 1'b0;
        bus.din_ready = 1'b0;
        bus.dout_valid = 1'b0;
        bus.state_we  = 1'b0;
        bus.key_we    = 1'b0;
        bus.tbc_start = 1'b0;
        s_adv         = 1'b0;
        k_adv         = 1'b0;
        if (!rst) begin
            case (state_q)
                ST_IDLE: begin
                    bus.cmd_ready = 1'b1;
                    if (bus.cmd_valid) begin
                        case (cmd_op_e'(bus.cmd_op))
                            OP_LOAD_STATE:   state_d = ST_LOAD_S;
                            OP_LOAD_KEY:     state_d = ST_LOAD_K;
                            OP_RUN:          state_d = ST_RUN;
                            OP_UNLOAD_STATE: state_d = ST_UNLOAD;
                            default:         state_d = ST_IDLE;
                        endcase
                    end
                end
                ST_LOAD_S: begin
                    bus.din_ready = 1'b1;
                    bus.state_we  = bus.din_valid;
                    s_adv         = bus.din_valid;
                    if (bus.din_valid && s_last) state_d = ST_IDLE;
                end
                ST_LOAD_K: begin
                    bus.din_ready = 1'b1;
                    bus.key_we    = bus.din_valid;
                    k_adv         = bus.din_valid;
                    if (bus.din_valid && k_last) state_d = ST_IDLE;
                end
                ST_RUN: begin
                    bus.tbc_start = !run_started_q;
                    if (bus.tbc_done) state_d = ST_IDLE;
                end
                ST_UNLOAD: begin
                    bus.dout_valid = 1'b1;
                    s_adv          = bus.dout_ready;
                    if (bus.dout_ready && s_last) state_d = ST_IDLE;
                end
                default: state_d = ST_IDLE;
            endcase
        end
    end

    assign idle_clr = (state_q == ST_IDLE);

    share_word_counter #(
        .SHARES(STATESHARES), .WORDS(WORDS), .WIDX_W(WIDX_W), .SIDX_W(SIDX_W)
    ) u_state_cnt (
        .clk(clk), .rst(rst), .clr(idle_clr), .adv(s_adv),
        .word_idx(s_word), .share_idx(s_share), .last(s_last)
    );

    share_word_counter #(
        .SHARES(KEYSHARES), .WORDS(WORDS), .WIDX_W(WIDX_W), .SIDX_W(SIDX_W)
    ) u_key_cnt (
        .clk(clk), .rst(rst), .clr(idle_clr), .adv(k_adv),
        .word_idx(k_word), .share_idx(k_share), .last(k_last)
    );

    assign bus.busy      = (state_q != ST_IDLE);
    assign bus.word_idx  = (state_q == ST_LOAD_K) ? k_word : s_word;
    assign bus.share_idx = (state_q == ST_LOAD_K) ? k_share : s_share;
    assign bus.wdata     = bus.din;

endmodule

// File: tb/tb_share_io_ctrl.sv
// Directed bench for share_io_ctrl: a position scoreboard is filled per
// operation and drained on every completed word transfer.
module tb_share_io_ctrl;
    import share_io_ctrl_pkg::*;

    localparam int BUSW   = CFG_BUSW;
    localparam int SS     = CFG_STATESHARES;
    localparam int KS     = CFG_KEYSHARES;
    localparam int WORDS  = 128 / BUSW;
    localparam int WIDX_W = idx_width(WORDS);
    localparam int SIDX_W = idx_width(SS > KS ? SS : KS);

    typedef struct packed {
        logic [WIDX_W-1:0] w;
        logic [SIDX_W-1:0] s;
    } pos_t;

    logic clk = 1'b0;
    logic rst;
    pos_t sb[$];
    int   n_checks = 0;
    int   n_fail   = 0;

    always #5 clk = ~clk;

    share_io_if #(.BUSW(BUSW), .WIDX_W(WIDX_W), .SIDX_W(SIDX_W)) bus ();

    share_io_ctrl #(.BUSW(BUSW), .STATESHARES(SS), .KEYSHARES(KS)) dut (
        .clk(clk), .rst(rst), .bus(bus)
    );

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("[TB] FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic applyStimulus(input logic dv, input logic dr, input logic td);
        bus.din_valid  = dv;
        bus.dout_ready = dr;
        bus.tbc_done   = td;
    endtask

    task automatic nextCycle();
        @(posedge clk);
        #1;
    endtask

    task automatic pushPairs(input int shares);
        pos_t p;
        for (int k = 0; k < WORDS * shares; k++) begin
            p.w = WIDX_W'(k / shares);
            p.s = SIDX_W'(k % shares);
            sb.push_back(p);
        end
    endtask

    task automatic issueCmd(input cmd_op_e op);
        bus.cmd_valid = 1'b1;
        bus.cmd_op    = op;
        #1;
        checkOutput("cmd_ready_idle", bus.cmd_ready, 1);
        nextCycle();
        bus.cmd_valid = 1'b0;
    endtask

    task automatic runLoad(input bit is_key, input bit toggle, input int exp_cycles);
        int   cyc = 0, pulses = 0, shares;
        bit   done = 0;
        logic dv, strobe, other;
        shares = is_key ? KS : SS;
        pushPairs(shares);
        while (cyc < 40) begin
            dv = toggle ? logic'(cyc[0]) : 1'b1;
            applyStimulus(dv, 1'b0, 1'b0);
            bus.din = BUSW'(32'hA5A5_0000 + cyc);
            #1;
            if (!bus.busy) begin
                done = 1;
                break;
            end
            if (sb.size() == 0) begin
                checkOutput("load_sb_underflow", 1, 0);
                break;
            end
            strobe = is_key ? bus.key_we : bus.state_we;
            other  = is_key ? bus.state_we : bus.key_we;
            if (cyc == 0) checkOutput("load_wdata", bus.wdata, bus.din);
            checkOutput("load_din_ready", bus.din_ready, 1);
            checkOutput("load_we", strobe, dv);
            checkOutput("load_other_we", other, 0);
            checkOutput("load_word_idx", bus.word_idx, sb[0].w);
            checkOutput("load_share_idx", bus.share_idx, sb[0].s);
            if (strobe) begin
                void'(sb.pop_front());
                pulses++;
            end
            nextCycle();
            cyc++;
        end
        applyStimulus(1'b0, 1'b0, 1'b0);
        checkOutput("load_done", done, 1);
        checkOutput("load_pulses", pulses, WORDS * shares);
        checkOutput("load_cycles", cyc, exp_cycles);
        checkOutput("load_sb_empty", sb.size(), 0);
        sb.delete();
    endtask

    task automatic runRun(input int done_at, input int exp_busy);
        int cyc = 0, starts = 0;
        bit done = 0;
        issueCmd(OP_RUN);
        while (cyc < 40) begin
            applyStimulus(1'b0, 1'b0, cyc == done_at);
            #1;
            if (!bus.busy) begin
                done = 1;
                break;
            end
            checkOutput("run_tbc_start", bus.tbc_start, cyc == 0);
            checkOutput("run_din_ready", bus.din_ready, 0);
            if (bus.tbc_start) starts++;
            nextCycle();
            cyc++;
        end
        applyStimulus(1'b0, 1'b0, 1'b0);
        checkOutput("run_done", done, 1);
        checkOutput("run_busy_cycles", cyc, exp_busy);
        checkOutput("run_starts", starts, 1);
    endtask

    task automatic runUnload();
        int   cyc = 0, xfers = 0, stall = 0;
        bit   done = 0;
        logic rdy;
        issueCmd(OP_UNLOAD_STATE);
        pushPairs(SS);
        while (cyc < 40) begin
            rdy = !(xfers == 5 && stall < 3);
            applyStimulus(1'b0, rdy, 1'b0);
            bus.cmd_valid = (cyc == 2);
            bus.cmd_op    = OP_LOAD_KEY;
            #1;
            if (!bus.busy) begin
                done = 1;
                break;
            end
            if (sb.size() == 0) begin
                checkOutput("unload_sb_underflow", 1, 0);
                break;
            end
            if (cyc == 2) checkOutput("unload_cmd_ready", bus.cmd_ready, 0);
            checkOutput("unload_dout_valid", bus.dout_valid, 1);
            checkOutput("unload_state_we", bus.state_we, 0);
            checkOutput("unload_word_idx", bus.word_idx, sb[0].w);
            checkOutput("unload_share_idx", bus.share_idx, sb[0].s);
            if (rdy) begin
                void'(sb.pop_front());
                xfers++;
            end else begin
                stall++;
            end
            nextCycle();
            cyc++;
        end
        bus.cmd_valid = 1'b0;
        applyStimulus(1'b0, 1'b0, 1'b0);
        checkOutput("unload_done", done, 1);
        checkOutput("unload_xfers", xfers, WORDS * SS);
        checkOutput("unload_stalls", stall, 3);
        checkOutput("unload_cycles", cyc, WORDS * SS + 3);
        checkOutput("unload_sb_empty", sb.size(), 0);
        sb.delete();
        nextCycle();
        #1;
        checkOutput("unload_stay_idle", bus.busy, 0);
        checkOutput("unload_idle_dout_valid", bus.dout_valid, 0);
    endtask

    initial begin
        #100000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog");
    end

    initial begin
        rst           = 1'b1;
        bus.cmd_valid = 1'b0;
        bus.cmd_op    = 2'b00;
        bus.din       = '0;
        applyStimulus(1'b0, 1'b0, 1'b0);
        nextCycle();
        nextCycle();
        #1;
        checkOutput("rst_busy", bus.busy, 0);
        checkOutput("rst_word_idx", bus.word_idx, 0);
        checkOutput("rst_share_idx", bus.share_idx, 0);
        checkOutput("rst_strobes", {bus.state_we, bus.key_we, bus.tbc_start, bus.din_ready, bus.dout_valid}, 0);
        rst = 1'b0;
        #1;
        checkOutput("rst_cmd_ready", bus.cmd_ready, 1);

        // A stray tbc_done while idle must not wake the controller.
        applyStimulus(1'b0, 1'b0, 1'b1);
        nextCycle();
        #1;
        checkOutput("idle_tbc_done_ignored", bus.busy, 0);
        applyStimulus(1'b0, 1'b0, 1'b0);

        $display("[TB] load state, din_valid held high");
        issueCmd(OP_LOAD_STATE);
        runLoad(1'b0, 1'b0, WORDS * SS);

        $display("[TB] load key, din_valid toggling");
        issueCmd(OP_LOAD_KEY);
        runLoad(1'b1, 1'b1, 2 * WORDS * KS);

        $display("[TB] run with late and same-cycle tbc_done");
        runRun(12, 13);
        runRun(0, 1);

        $display("[TB] unload with back-pressure and ignored command");
        runUnload();

        $display("[TB] reset abort during state load");
        issueCmd(OP_LOAD_STATE);
        applyStimulus(1'b1, 1'b0, 1'b0);
        for (int c = 0; c < 3; c++) nextCycle();
        rst = 1'b1;
        #1;
        checkOutput("abort_no_we", bus.state_we, 0);
        checkOutput("abort_no_din_ready", bus.din_ready, 0);
        nextCycle();
        rst = 1'b0;
        applyStimulus(1'b0, 1'b0, 1'b0);
        #1;
        checkOutput("abort_busy", bus.busy, 0);
        checkOutput("abort_word_idx", bus.word_idx, 0);
        checkOutput("abort_share_idx", bus.share_idx, 0);
        issueCmd(OP_LOAD_STATE);
        runLoad(1'b0, 1'b0, WORDS * SS);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/share_io_ctrl.md
SHARE_IO_CTRL -- requirements
Module: share_io_ctrl

Interface
REQ-001 Parameter BUSW, default 32, bus word width in bits; 128 SHALL be divisible by BUSW; value comes from romulus_config_pkg.v.
REQ-002 Parameter STATESHARES, default 2, number of state shares; value comes from romulus_config_pkg.v.
REQ-003 Parameter KEYSHARES, default 2, number of key shares; value comes from romulus_config_pkg.v.
REQ-004 The block SHALL use one clock; reset is synchronous and active-high.
REQ-005 clk  in  1  system clock; all state updates on the rising edge.
REQ-006 rst  in  1  synchronous, active-high reset.
REQ-007 cmd_valid  in  1  command offered.
REQ-008 cmd_op  in  2  command: 00 LOAD_STATE, 01 LOAD_KEY, 10 RUN, 11 UNLOAD_STATE.
REQ-009 cmd_ready  out  1  high only in IDLE; a command is accepted when cmd_valid and cmd_ready are both high.
REQ-010 din_valid / din_ready  in / out  1 / 1  input word handshake.
REQ-011 din  in  BUSW  interleaved share word; routed to the datapath unchanged.
REQ-012 dout_valid / dout_ready  out / in  1 / 1  output word handshake.
REQ-013 state_we / key_we  out  1 / 1  write strobe for the bus-facing state or key register word.
REQ-014 word_idx  out  clog2(128/BUSW)  current word index j.
REQ-015 share_idx  out  clog2(max(STATESHARES,KEYSHARES)), minimum 1 bit  current share index i.
REQ-016 tbc_start  out  1  one-cycle pulse that starts the masked TBC.
REQ-017 tbc_done  in  1  TBC completion pulse.
REQ-018 busy  out  1  high whenever the FSM is not in IDLE.

Function
REQ-019 FSM states SHALL be IDLE, LOAD_S, LOAD_K, RUN, UNLOAD; each accepted cmd_op moves IDLE to the matching state.
REQ-020 Word order SHALL be share-interleaved: transfer k carries word j = k / SHARES and share i = k % SHARES. share_idx is the inner counter and word_idx the outer counter.
REQ-021 LOAD_S SHALL take exactly 128/BUSW*STATESHARES transfers; LOAD_K SHALL take 128/BUSW*KEYSHARES transfers.
REQ-022 In LOAD_S/LOAD_K: din_ready=1; state_we/key_we = din_valid & din_ready (combinational); counters advance only on a completed transfer.
REQ-023 On the last transfer of a load, the counters SHALL wrap to 0 and the FSM SHALL return to IDLE in the next cycle.
REQ-024 RUN: tbc_start SHALL pulse in the first RUN cycle only; the FSM SHALL stay in RUN until tbc_done, then go to IDLE on the next edge.
REQ-025 A tbc_done in the same cycle as tbc_start SHALL be honoured, giving a minimum RUN duration of 1 cycle.
REQ-026 UNLOAD: dout_valid=1, with 128/BUSW*STATESHARES transfers in the same order as the load; counters advance on dout_valid & dout_ready.
REQ-027 dout_valid SHALL stay high, and word_idx and share_idx SHALL stay stable, while dout_ready is low.
REQ-028 Outside their own states, din_ready, dout_valid, state_we, key_we and tbc_start SHALL be 0; tbc_done outside RUN SHALL be ignored.
REQ-029 cmd_valid while busy SHALL be ignored because cmd_ready=0; there is no queuing.
REQ-030 Throughput SHALL be one word per cycle with no bubble between consecutive transfers.

Reset
REQ-031 rst SHALL force IDLE, word_idx=0, share_idx=0, busy=0, cmd_ready=1, and all strobes and valids to 0 on the next edge.
REQ-032 rst mid-load, mid-RUN or mid-UNLOAD SHALL abort the operation with no further strobes.
REQ-033 rst has priority over every handshake in the same cycle.

Structure
REQ-034 BUSW, STATESHARES, KEYSHARES and the cmd_op encodings SHALL live in romulus_config_pkg.v.
REQ-035 A sub-module share_word_counter (share/word counter with wrap and last flag, parameterised by share count) SHALL be used once for the state share count and once for the key share count.

Verification
REQ-036 BUSW=32, STATESHARES=2: LOAD_S with din_valid always high -> 8 state_we pulses, (word_idx,share_idx) = (0,0),(0,1),(1,0)…(3,1), then IDLE.
REQ-037 LOAD_K with din_valid toggling every other cycle -> exactly 8 key_we pulses over 16 cycles, counters advancing only on valid cycles.
REQ-038 RUN with tbc_done 12 cycles after start -> one tbc_start pulse, busy high 13 cycles; a same-cycle tbc_done -> busy high 1 cycle.
REQ-039 UNLOAD with dout_ready low for 3 cycles at transfer 5 -> dout_valid held with word_idx=2, share_idx=1 stable; 8 transfers total.
REQ-040 rst asserted at transfer 3 of LOAD_S -> the next cycle is IDLE with counters 0; a new LOAD_S restarts at (0,0).
REQ-041 cmd_valid pulsed during UNLOAD -> ignored, with no state change after UNLOAD completes.
